// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline control logic.
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun  = 2'b00,
        StWait = 2'b01,
        StErr  = 2'b10
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage read of a register that the load currently in EX has not yet produced.
module load_use_detect
    import mips_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    output logic       lu_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rd_i == id_rs_i);
    assign rt_match = id_uses_rt_i && (ex_rd_i == id_rt_i);

    // $zero is never a real dependency, so it must not stall.
    assign lu_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, MEM-stage branch flushes,
// data-memory wait handshake with timeout, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_src,
    output logic             dmem_req,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles
);

    // wait_cnt never exceeds TIMEOUT-1.
    localparam int unsigned WaitW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic lu;
    logic br;
    logic mem_stall;

    load_use_detect u_load_use_detect (
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .lu_o          (lu)
    );

    assign br = mem_branch && mem_zero;

    assign mem_stall = ((state_q == StRun) && mem_access && !dmem_ready) ||
                       ((state_q == StWait) && !dmem_ready);

    always_comb begin : next_state
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun: begin
                if (mem_access && !dmem_ready) begin
                    state_d    = StWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StWait: begin
                if (dmem_ready) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
                    state_d = StErr;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin : outputs
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_src      = 1'b0;
        dmem_req    = 1'b0;
        bus_err     = 1'b0;

        if (state_q == StErr) begin
            bus_err = 1'b1;
        end else begin
            dmem_req = ((state_q == StRun) && mem_access) || (state_q == StWait);
            if (mem_stall) begin
                pc_en = 1'b0;
            end else if (br) begin
                // Taken branch overrides load-use: the dependent instruction is squashed anyway.
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                {ifid_flush, idex_flush, exmem_flush}        = 3'b111;
                pc_src                                        = 1'b1;
            end else if (lu) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00111;
                idex_flush                                    = 1'b1;
            end else begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            end
        end

        if (!rst_n) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            {ifid_flush, idex_flush, exmem_flush}        = 3'b000;
            pc_src                                        = 1'b0;
            dmem_req                                      = 1'b0;
            bus_err                                       = 1'b0;
        end
    end

    always_comb begin : stall_count
        stall_d = stall_q;
        if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with TIMEOUT=4 and a 4-bit stall counter.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       emr;
        logic [4:0] rd;
        logic       mb;
        logic       mz;
        logic       ma;
        logic       rdy;
    } in_t;

    // {enables pc..memwb, flushes ifid..exmem, pc_src, dmem_req, bus_err, stall_cycles}
    typedef struct packed {
        logic [10:0] o;
        logic [3:0]  cnt;
    } exp_t;

    localparam logic [10:0] O_NORM = {5'b11111, 3'b000, 3'b000};
    localparam logic [10:0] O_LU   = {5'b00111, 3'b010, 3'b000};
    localparam logic [10:0] O_BR   = {5'b11111, 3'b111, 3'b100};
    localparam logic [10:0] O_MST  = {5'b00000, 3'b000, 3'b010};
    localparam logic [10:0] O_MOK  = {5'b11111, 3'b000, 3'b010};
    localparam logic [10:0] O_MBR  = {5'b11111, 3'b111, 3'b110};
    localparam logic [10:0] O_MLU  = {5'b00111, 3'b010, 3'b010};
    localparam logic [10:0] O_ERR  = {5'b00000, 3'b000, 3'b001};
    localparam logic [10:0] O_RST  = 11'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_mem_read, mem_branch, mem_zero, mem_access, dmem_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, pc_src, dmem_req, bus_err;
    logic [3:0] stall_cycles;

    exp_t       exp_q[$];
    logic [3:0] cnt_m;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .mem_branch   (mem_branch),
        .mem_zero     (mem_zero),
        .mem_access   (mem_access),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .pc_src       (pc_src),
        .dmem_req     (dmem_req),
        .bus_err      (bus_err),
        .stall_cycles (stall_cycles)
    );

    function automatic in_t mk(logic [4:0] rs, logic [4:0] rt, logic urt, logic emr,
                               logic [4:0] rd, logic mb, logic mz, logic ma, logic rdy);
        in_t i;
        i = '{rs, rt, urt, emr, rd, mb, mz, ma, rdy};
        return i;
    endfunction

    function automatic exp_t observe();
        exp_t g;
        g.o   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, pc_src, dmem_req, bus_err};
        g.cnt = stall_cycles;
        return g;
    endfunction

    task automatic apply(input in_t i, input logic [10:0] o);
        exp_t e;
        {id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
         mem_branch, mem_zero, mem_access, dmem_ready} = i;
        e.o   = o;
        e.cnt = cnt_m;
        exp_q.push_back(e);
    endtask

    // Clock edge plus the bench's own stall-counter model, then park on the next falling edge.
    task automatic adv(input exp_t e);
        @(posedge clk);
        if (!e.o[10] && cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), O_NORM);
        void'(exp_q.pop_front());
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cnt_m = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t got, e;
        rst_n = 1'b0;
        cnt_m = 4'd0;
        for (int k = 0; k < 2; k++) begin
            apply(mk(5'd8, 5'd8, 1, 1, 5'd8, 1, 1, 1, 0), O_RST);
            #1;
            got = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL reset row %0d: got %h, expected %h", k, got, e);
            end
            @(negedge clk);
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), O_NORM);
        void'(exp_q.pop_front());
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        in_t         ins[6];
        logic [10:0] outs[6];
        exp_t        got, e;
        ins[0] = mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 0, 0);  outs[0] = O_LU;
        ins[1] = mk(5'd8, 5'd0, 0, 0, 5'd8, 0, 0, 0, 0);  outs[1] = O_NORM;
        ins[2] = mk(5'd3, 5'd9, 1, 1, 5'd9, 0, 0, 0, 0);  outs[2] = O_LU;
        ins[3] = mk(5'd3, 5'd9, 0, 1, 5'd9, 0, 0, 0, 0);  outs[3] = O_NORM;
        ins[4] = mk(5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0);  outs[4] = O_NORM;
        ins[5] = mk(5'd4, 5'd5, 1, 1, 5'd6, 0, 0, 0, 0);  outs[5] = O_NORM;
        for (int k = 0; k < 6; k++) begin
            apply(ins[k], outs[k]);
            #1;
            got = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL load_use row %0d: got %h, expected %h", k, got, e);
            end
            adv(e);
        end
    endtask

    task automatic test_branch();
        in_t         ins[4];
        logic [10:0] outs[4];
        exp_t        got, e;
        ins[0] = mk(5'd1, 5'd2, 1, 0, 5'd7, 1, 1, 0, 0);  outs[0] = O_BR;
        ins[1] = mk(5'd1, 5'd2, 1, 0, 5'd7, 1, 0, 0, 0);  outs[1] = O_NORM;
        ins[2] = mk(5'd8, 5'd0, 0, 1, 5'd8, 1, 1, 0, 0);  outs[2] = O_BR;
        ins[3] = mk(5'd1, 5'd2, 1, 0, 5'd7, 0, 1, 0, 0);  outs[3] = O_NORM;
        for (int k = 0; k < 4; k++) begin
            apply(ins[k], outs[k]);
            #1;
            got = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL branch row %0d: got %h, expected %h", k, got, e);
            end
            adv(e);
        end
    endtask

    task automatic test_mem_latency();
        in_t         ins[10];
        logic [10:0] outs[10];
        exp_t        got, e;
        ins[0] = mk(5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);  outs[0] = O_MST;
        ins[1] = mk(5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);  outs[1] = O_MST;
        ins[2] = mk(5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 1);  outs[2] = O_MOK;
        ins[3] = mk(5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 1);  outs[3] = O_NORM;
        ins[4] = mk(5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 1);  outs[4] = O_MOK;
        ins[5] = mk(5'd8, 5'd0, 0, 1, 5'd8, 1, 1, 1, 0);  outs[5] = O_MST;
        ins[6] = mk(5'd8, 5'd0, 0, 1, 5'd8, 1, 1, 1, 1);  outs[6] = O_MBR;
        ins[7] = mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 1, 0);  outs[7] = O_MST;
        ins[8] = mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 1, 1);  outs[8] = O_MLU;
        ins[9] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);  outs[9] = O_NORM;
        for (int k = 0; k < 10; k++) begin
            apply(ins[k], outs[k]);
            #1;
            got = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL mem_latency row %0d: got %h, expected %h", k, got, e);
            end
            adv(e);
        end
    endtask

    task automatic test_timeout();
        in_t         ins[7];
        logic [10:0] outs[7];
        exp_t        got, e;
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            ins[k] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
            outs[k] = O_MST;
        end
        ins[4] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);  outs[4] = O_ERR;
        ins[5] = mk(5'd8, 5'd0, 0, 1, 5'd8, 1, 1, 1, 1);  outs[5] = O_ERR;
        ins[6] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);  outs[6] = O_ERR;
        for (int k = 0; k < 7; k++) begin
            apply(ins[k], outs[k]);
            #1;
            got = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL timeout row %0d: got %h, expected %h", k, got, e);
            end
            adv(e);
        end
        // Asynchronous clear out of ERR, between clock edges.
        #2;
        rst_n = 1'b0;
        cnt_m = 4'd0;
        apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0), O_RST);
        #1;
        got = observe();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_errors++;
            $display("FAIL timeout_clear: got %h, expected %h", got, e);
        end
        apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0), O_NORM);
        void'(exp_q.pop_front());
        rst_n = 1'b1;
        @(negedge clk);
        apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0), O_NORM);
        #1;
        got = observe();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_errors++;
            $display("FAIL timeout_back_to_run: got %h, expected %h", got, e);
        end
        adv(e);
    endtask

    task automatic test_reset_mid_wait();
        exp_t got, e;
        for (int k = 0; k < 2; k++) begin
            apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0), O_MST);
            #1;
            got = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL mid_wait row %0d: got %h, expected %h", k, got, e);
            end
            if (k == 0) adv(e);
        end
        #1;
        rst_n = 1'b0;
        cnt_m = 4'd0;
        apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0), O_RST);
        #1;
        got = observe();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_errors++;
            $display("FAIL mid_wait_reset: got %h, expected %h", got, e);
        end
        apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0), O_NORM);
        void'(exp_q.pop_front());
        rst_n = 1'b1;
        @(negedge clk);
        apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0), O_NORM);
        #1;
        got = observe();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_errors++;
            $display("FAIL mid_wait_run: got %h, expected %h", got, e);
        end
        adv(e);
    endtask

    task automatic test_saturation();
        exp_t got, e;
        reset_dut();
        for (int k = 0; k < 20; k++) begin
            apply(mk(5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 0, 0), O_LU);
            #1;
            got = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL saturation row %0d: got %h, expected %h", k, got, e);
            end
            adv(e);
        end
        apply(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0), O_NORM);
        void'(exp_q.pop_front());
        #1;
        n_checks++;
        if (stall_cycles !== 4'hF) begin
            n_errors++;
            $display("FAIL saturation_final: got %0d, expected 15", stall_cycles);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        @(negedge clk);
        test_load_use();
        test_branch();
        test_mem_latency();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It produces load-enable and flush (NOP-insert) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles three cases: load-use hazards, branches resolved in MEM, and multi-cycle data-memory accesses via a req/ready handshake with a timeout. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum wait cycles on the data memory before bus error (≥2).
- `CNT_W`, 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_rs`  in  5  rs field of instruction in ID.
- `id_rt`  in  5  rt field of instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads rt (R-type, beq, sw).
- `ex_mem_read`  in  1  MemRead of instruction in EX (ID/EX M bit).
- `ex_rd`  in  5  destination register of instruction in EX.
- `mem_branch`  in  1  Branch bit of EX/MEM M field.
- `mem_zero`  in  1  EX/MEM zero flag.
- `mem_access`  in  1  MemRead|MemWrite of instruction in MEM.
- `dmem_ready`  in  1  data memory completes current access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  register load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`  out  1 each  load all-zero control/NOP on next edge (only meaningful with the matching `_en`=1).
- `pc_src`  out  1  select branch target for next PC.
- `dmem_req`  out  1  data memory request.
- `bus_err`  out  1  sticky timeout error.
- `stall_cycles`  out  `CNT_W`  saturating count of cycles with `pc_en`=0.

## Operation
- States: RUN, WAIT, ERR (encoding in package). Reset → RUN.
- Definitions:
  - `lu` = `ex_mem_read` && `ex_rd`≠0 && (`ex_rd`==`id_rs` || (`id_uses_rt` && `ex_rd`==`id_rt`)).
  - `br` = `mem_branch` && `mem_zero`.
- Priority: ERR > memory stall > branch > load-use > normal.
- Normal case: all enables 1, all flushes 0, `pc_src`=0.
- RUN, `mem_access`=1, `dmem_ready`=0:
  - `dmem_req`=1, all five enables 0, flushes 0, `pc_src`=0.
  - Next state WAIT, `wait_cnt`←1.
- RUN, `mem_access`=1, `dmem_ready`=1: `dmem_req`=1, no stall. Evaluate `br`/`lu` as below.
- WAIT:
  - `dmem_req`=1.
  - `dmem_ready`=0: enables 0. If `wait_cnt`==`TIMEOUT`-1 → ERR, else `wait_cnt`+1.
  - `dmem_ready`=1: normal enables, `br`/`lu` evaluated, → RUN.
- Branch (`br`, not memory-stalled):
  - `pc_src`=1; `ifid_flush`=`idex_flush`=`exmem_flush`=1.
  - All enables 1. `lu` ignored.
- Load-use (`lu`, no `br`, not memory-stalled):
  - `pc_en`=`ifid_en`=0; `idex_en`=1 with `idex_flush`=1 (bubble).
  - `exmem_en`=`memwb_en`=1. Exactly one bubble per hazard.
- ERR: all enables 0, `dmem_req`=0, `bus_err`=1. Held until reset.
- `stall_cycles` increments at each edge where `pc_en`=0, and saturates at all-ones.
- While `rst_n`=0, outputs are forced:
  - all enables 0, all flushes 0, `pc_src`=0, `dmem_req`=0, `bus_err`=0.
  - `stall_cycles`=0, `wait_cnt`=0.

## Timing
- Outputs are combinational from state and inputs, with zero-cycle response; registered pipeline effects appear at the next edge.
- Load-use costs exactly 1 stall cycle. Taken branch costs 3 flushed slots, with no stall.
- A memory access with latency N cycles (ready in the Nth cycle of `dmem_req`) freezes the pipeline for N-1 cycles.
- Timeout: ERR entered at the edge ending the `TIMEOUT`th request cycle without ready.
- `dmem_ready` outside an access (`mem_access`=0) is ignored.
- Reset mid-WAIT returns to RUN immediately and asynchronously; `dmem_req` drops without waiting for ready.
- `ex_rd`=0 never causes a stall.
- Counters are updated only on `clk` rising edges; the reset clear is asynchronous.

## Structure
- Package `mips_ctrl_pkg`: state enum (RUN, WAIT, ERR) and the REG_ZERO constant (5'd0).
- Sub-module `load_use_detect` (combinational comparator producing `lu`), instantiated once; the FSM, counters and output muxing stay in the top.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=8, `id_rs`=8 → one cycle with `pc_en`=`ifid_en`=0 and `idex_flush`=1; `stall_cycles` increments to 1.
- `ex_rd`=0 = `id_rs`=0 with `ex_mem_read`=1 → no stall; all enables 1.
- Branch plus load-use in the same cycle: `br`=1, `lu`=1 → `pc_src`=1, three flushes 1, `pc_en`=1.
- Memory latency 3: `mem_access`=1, `dmem_ready` high on the 3rd cycle → enables 0 for 2 cycles, `dmem_req`=1 for 3 cycles, state back to RUN.
- Timeout with `TIMEOUT`=4 and `dmem_ready` held 0 → `bus_err`=1 after 4 request cycles; enables stay 0; `rst_n` pulse clears to RUN with `bus_err`=0.
- Saturation with `CNT_W`=4: 20 stall cycles → `stall_cycles`=15.
